// File: rtl/cdc_hs_sender.sv
// cdc_hs_sender
//   Source-side half of a 4-phase req/ack bus synchronizer. A word is
//   accepted with a valid/ready handshake. It is then held on data_out while
//   req_out is raised toward the destination domain. The asynchronous ack is
//   synchronized locally, and the full 4-phase cycle completes before the
//   next word is accepted. A sticky error flag is raised if the far end does
//   not answer within TIMEOUT cycles.
//
// Parameters
//   WIDTH        data word width
//   SYNC_STAGES  flops in the ack_async synchronizer chain (2..4)
//   TIMEOUT      cycles allowed in REQ or DROP before ERR; 0 disables
//
// Ports
//   clk         clock, all flops on the rising edge
//   rst         synchronous active-high reset
//   send_valid  local request to transfer send_data
//   send_data   word to transfer, sampled on accept
//   send_ready  a new word can be accepted this cycle
//   req_out     registered 4-phase request
//   data_out    held word, stable whenever req_out=1
//   ack_async   asynchronous acknowledge from the destination domain
//   done        one-cycle pulse when a 4-phase cycle completes
//   error       sticky timeout flag
//   clear_err   leaves ERR (once ack is low) and clears error
module cdc_hs_sender #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_valid,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_async,
  output logic             done,
  output logic             error,
  input  logic             clear_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_req, w_req_nxt;
  logic [WIDTH-1:0]       r_data, w_data_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   w_ack_sync;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_timeout;

  // ack_async feeds the first stage only; the FSM sees the last stage
  always_ff @(posedge clk) begin
    if (rst) r_ack_sync <= '0;
    else     r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
  end

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

  // A stale ack left high from an aborted cycle blocks acceptance
  assign w_ready   = (r_state == S_IDLE) && !rst && !w_ack_sync;
  assign w_accept  = send_valid && w_ready;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_data_nxt  = send_data;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack_sync) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DROP;
        end else if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERR;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DROP: begin
        if (!w_ack_sync) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERR;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ERR: begin
        w_req_nxt = 1'b0;
        if (clear_err && !w_ack_sync) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign send_ready = w_ready;
  assign req_out    = r_req;
  assign data_out   = r_data;
  assign done       = r_done;
  assign error      = r_err;

endmodule

// File: tb/tb_cdc_hs_sender.sv
module tb_cdc_hs_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_async;
  logic       done;
  logic       error;
  logic       clear_err;

  logic       echo_en;
  logic       ack_force;
  logic [2:0] echo_pipe;
  logic       m_s0, m_s1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cdc_hs_sender #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send_valid(send_valid),
    .send_data (send_data),
    .send_ready(send_ready),
    .req_out   (req_out),
    .data_out  (data_out),
    .ack_async (ack_async),
    .done      (done),
    .error     (error),
    .clear_err (clear_err)
  );

  // Far-end responder: echoes req_out back after three cycles
  always @(posedge clk) echo_pipe <= {echo_pipe[1:0], req_out};
  assign ack_async = echo_en ? echo_pipe[2] : ack_force;

  // Bench-side model of the two-stage ack synchronizer
  always @(posedge clk) begin
    if (rst) begin
      m_s0 <= 1'b0;
      m_s1 <= 1'b0;
    end else begin
      m_s0 <= ack_async;
      m_s1 <= m_s0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  first_low, first_err, done_cnt, done_at, acc2_at, first_hi;
  logic prev_req;
  logic bad_rise;
  logic data_bad;

  initial begin
    rst = 1'b1; send_valid = 1'b0; send_data = 8'h00; clear_err = 1'b0;
    echo_en = 1'b0; ack_force = 1'b0; echo_pipe = '0;

    // Reset then idle
    repeat (3) tick();
    check("rst_req",   32'(req_out),    32'd0);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_err",   32'(error),      32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_ready", 32'(send_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(send_ready), 32'd1);

    // Single transfer 0xAB with echoing responder
    echo_en = 1'b1;
    send_data = 8'hAB; send_valid = 1'b1;
    tick();
    send_valid = 1'b0;
    check("t1_req",   32'(req_out),    32'd1);
    check("t1_data",  32'(data_out),   32'hAB);
    check("t1_ready", 32'(send_ready), 32'd0);
    first_low = -1; done_cnt = 0; done_at = -1; data_bad = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (!req_out && first_low < 0) first_low = k;
      if (done) begin done_cnt++; done_at = k; end
      if (data_out !== 8'hAB) data_bad = 1'b1;
      if (k == 12) check("t1_ready_after_done", 32'(send_ready), 32'd1);
    end
    check("t1_req_fall", 32'(first_low), 32'd6);
    check("t1_done_at",  32'(done_at),   32'd12);
    check("t1_done_cnt", 32'(done_cnt),  32'd1);
    check("t1_data_hold", 32'(data_bad), 32'd0);

    // Back-to-back 0x55 then 0xDA
    send_data = 8'h55; send_valid = 1'b1;
    tick();
    check("b2b_data1", 32'(data_out), 32'h55);
    send_data = 8'hDA;
    done_cnt = 0; acc2_at = -1; bad_rise = 1'b0; data_bad = 1'b0;
    prev_req = req_out;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (req_out && !prev_req && m_s1) bad_rise = 1'b1;
      prev_req = req_out;
      if (done) done_cnt++;
      if (acc2_at < 0 && data_out === 8'hDA) begin
        acc2_at = k;
        send_valid = 1'b0;
      end
      if (acc2_at < 0 && data_out !== 8'h55) data_bad = 1'b1;
    end
    check("b2b_acc2_at",   32'(acc2_at),  32'd13);
    check("b2b_done_cnt",  32'(done_cnt), 32'd2);
    check("b2b_rise_ack",  32'(bad_rise), 32'd0);
    check("b2b_hold_55",   32'(data_bad), 32'd0);

    // Timeout with ack tied low
    echo_en = 1'b0; ack_force = 1'b0;
    send_data = 8'h77; send_valid = 1'b1;
    tick();
    send_valid = 1'b0;
    first_low = -1; first_err = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!req_out && first_low < 0) first_low = k;
      if (error && first_err < 0) first_err = k;
    end
    check("to_req_fall", 32'(first_low), 32'd16);
    check("to_err_at",   32'(first_err), 32'd16);
    check("to_ready",    32'(send_ready), 32'd0);
    check("to_data",     32'(data_out),  32'h77);
    clear_err = 1'b1; send_valid = 1'b1; send_data = 8'h11;
    tick();
    clear_err = 1'b0; send_valid = 1'b0;
    check("clr_err",   32'(error),      32'd0);
    check("clr_noacc", 32'(req_out),    32'd0);
    check("clr_ready", 32'(send_ready), 32'd1);
    check("clr_data",  32'(data_out),   32'h77);

    // Stale ack blocks acceptance
    rst = 1'b1; ack_force = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("stale_ready", 32'(send_ready), 32'd0);
    send_data = 8'h3C; send_valid = 1'b1;
    repeat (4) tick();
    check("stale_noacc", 32'(req_out), 32'd0);
    ack_force = 1'b0;
    first_hi = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (req_out && first_hi < 0) begin
        first_hi = k;
        send_valid = 1'b0;
      end
    end
    check("stale_acc_at", 32'(first_hi), 32'd3);
    check("stale_data",   32'(data_out), 32'h3C);

    // Reset mid-REQ
    check("mid_req_hi", 32'(req_out), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_req",   32'(req_out),    32'd0);
    check("mid_data",  32'(data_out),   32'd0);
    check("mid_done",  32'(done),       32'd0);
    check("mid_err",   32'(error),      32'd0);
    check("mid_ready", 32'(send_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_idle_ready", 32'(send_ready), 32'd1);
    done_cnt = 0;
    repeat (4) begin
      tick();
      if (done) done_cnt++;
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_hs_sender.md
Name: cdc_hs_sender

Overview:
Source-side half of a 4-phase req/ack bus synchronizer for the fing synchronizer demo; the counterpart of the destination-domain capture path.
- Accepts a word in the local clk domain with a valid/ready handshake, holds it stable on data_out and drives req_out across the crossing.
- Synchronizes the returning asynchronous ack internally and completes the full 4-phase cycle.
- Flags a timeout if the far end never answers.

Parameters:
WIDTH, 8, data word width.
SYNC_STAGES, 2, flip-flops in the ack_async synchronizer chain (legal values 2..4).
TIMEOUT, 255, cycles allowed in either wait state before error; 0 disables the timeout.

Ports:
clk  input  1  single clock; every flop is on its rising edge.
rst  input  1  synchronous, active-high reset.
send_valid  input  1  local request to transfer send_data.
send_data  input  WIDTH  word to transfer; sampled on accept.
send_ready  output  1  high when a new word can be accepted.
req_out  output  1  4-phase request to the destination domain; registered, glitch-free.
data_out  output  WIDTH  held word; stable whenever req_out=1.
ack_async  input  1  acknowledge from the destination clock domain; asynchronous.
done  output  1  one-cycle pulse when a 4-phase cycle completes.
error  output  1  sticky timeout flag.
clear_err  input  1  clears error and leaves the ERR state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; req_out=0, data_out=0, done=0, error=0, timeout counter=0.
  - All synchronizer stages are 0.
  - send_ready is 0 while rst=1.
- ack_sync is ack_async passed through the SYNC_STAGES-flop chain. The FSM uses only ack_sync, never ack_async directly.
- send_ready = (state==IDLE) and not rst. Accept = send_valid and send_ready.
- IDLE:
  - On accept at edge N: data_out <= send_data, req_out <= 1, state <= REQ, counter cleared. Both outputs are visible after edge N.
  - If ack_sync=1 while in IDLE (stale ack), the block does not accept and stays in IDLE until ack_sync=0. send_ready is low during this time.
- REQ:
  - req_out=1. On ack_sync=1: req_out <= 0, state <= DROP, counter cleared.
  - Otherwise the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1: state <= ERR, req_out <= 0, error <= 1.
- DROP:
  - req_out=0. On ack_sync=0: done <= 1 for exactly one cycle, state <= IDLE. send_ready is high on the cycle after the done edge.
  - Otherwise the same timeout rule as REQ applies.
- ERR:
  - req_out=0, error=1, send_ready=0.
  - When clear_err=1 and ack_sync=0: error <= 0, state <= IDLE.
  - clear_err in any other state has no effect.
- data_out changes only on accept; it keeps its last value through DROP, ERR and IDLE.
- send_data changes while not ready are ignored.
- Minimum cycle (ack assumed to toggle instantly at the far end): accept at edge 0, req_out high at 0. ack_sync high by edge SYNC_STAGES; req_out low at SYNC_STAGES+1. done after about 2*SYNC_STAGES+2 edges.
- Counter width is clog2(TIMEOUT+1), saturating; no wrap-around.
- rst asserted mid-transfer:
  - Everything returns to reset values at that edge, with no done and no error.
  - A stale ack still high then blocks IDLE acceptance until it falls (IDLE rule).
- Simultaneous clear_err and send_valid in ERR: only the exit is taken; accept is evaluated from the next cycle.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> req_out=0, data_out=0, error=0, done=0, send_ready=0 during reset and 1 after.
- Single transfer, send_data=0xAB, responder echoes req_out to ack_async after 3 cycles -> data_out=0xAB from the accept edge, req_out high until ack_sync rises, one done pulse, send_ready back high. data_out stays 0xAB throughout.
- Back-to-back: send_valid held high with 0x55 then 0xDA -> second accept only after done. Exactly two done pulses, and req_out never rises while ack_sync=1.
- Timeout, TIMEOUT=16, ack_async tied 0 -> req_out falls and error=1 exactly 16 cycles after entering REQ. Then clear_err=1 -> IDLE, error=0.
- Stale ack: ack_async=1 after reset with send_valid=1 -> no accept and send_ready=0. Drop ack -> accept SYNC_STAGES+1 cycles later.
- Reset mid-REQ: rst pulsed while req_out=1 -> req_out=0 and data_out=0 next edge, no done, state IDLE.
